apb_event_sink: RTL and testbench
=================================

Name: apb_event_sink

Overview:
- APB completer directly downstream of the event-to-APB write master.
- Accepts the master's counter-snapshot writes to the three event addresses, holds them in three 32-bit shadow registers and inserts a programmable number of wait states.
- Flags writes to unmapped addresses, checks each register for non-monotonic updates, and supports read-back for debug/firmware.

Parameters:
WAIT_CYCLES, 1, access-phase wait states before PREADY (legal 0..15)
ADDR_A, 32'hABBA0000, address of event-A register
ADDR_B, 32'hBAFF0000, address of event-B register
ADDR_C, 32'hCAFE0000, address of event-C register

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
apb_psel_i  in  1  APB select
apb_penable_i  in  1  APB enable
apb_paddr_i  in  32  APB address
apb_pwrite_i  in  1  1=write, 0=read
apb_pwdata_i  in  32  write data
apb_pready_o  out  1  transfer complete
apb_prdata_o  out  32  read data
apb_pslverr_o  out  1  error response (unmapped address)
reg_a_o / reg_b_o / reg_c_o  out  32 each  shadow register values
upd_o  out  3  one-cycle update pulse per register, bit0=A, bit1=B, bit2=C
seq_err_o  out  3  sticky non-monotonic flag per register
proto_err_o  out  1  sticky: PSEL dropped during access phase
clr_err_i  in  1  clears seq_err_o and proto_err_o

Behaviour:
- Reset (async, any time including mid-transfer):
  - FSM to IDLE; all outputs, registers and valid bits go to 0.
  - Any in-flight transfer is abandoned with no register update.
- FSM states: IDLE, ACCESS.
  - IDLE: on psel=1, penable=0 (setup phase), load wait counter with WAIT_CYCLES and go to ACCESS. Latch paddr, pwrite and pwdata at this edge.
  - ACCESS, psel=1 and penable=1:
    - cnt!=0: decrement; pready_o=0.
    - cnt==0: pready_o=1 this cycle (combinational from state, cnt, psel, penable); next state IDLE.
  - ACCESS, psel=0: protocol violation. Set proto_err_o, go to IDLE, no update.
- Latency: PREADY asserts in access-phase cycle WAIT_CYCLES+1. WAIT_CYCLES=0 gives a zero-wait transfer.
- Address decode: full 32-bit compare against ADDR_A/B/C on the latched address. Any other address is unmapped.
- Completion cycle (pready_o=1):
  - Unmapped address: pslverr_o=1, prdata_o=0, no state change.
  - Mapped read: prdata_o = selected register; pslverr_o=0.
  - Mapped write: selected register is written at the next edge and its upd_o bit pulses high for exactly that following cycle.
  - prdata_o and pslverr_o are 0 in every cycle other than the completion cycle.
- Monotonic check on each mapped write:
  - Applies only when the slot's valid bit is already 1; the first write after reset only sets valid.
  - Sets the slot's seq_err bit if new <= old, except old=32'hFFFFFFFF to new=0 (wrap), which is legal.
  - Equal value is an error.
- Error clearing: clr_err_i clears all sticky error bits at the next edge. A set in the same cycle wins over clear.
- Back-to-back transfers: each transfer needs a fresh setup phase. A new setup may arrive in the cycle after completion (IDLE).
- pwdata is sampled at setup. Changes during access are ignored.

Decomposition:
- Package apb_event_sink_pkg holds:
  - the state enum (IDLE, ACCESS);
  - the slot index enum (SLOT_A, SLOT_B, SLOT_C, SLOT_NONE);
  - default address constants;
  - the 4-bit wait counter width.
- Sub-module event_reg_slot, instantiated three times. It holds value, valid bit, monotonic check, upd pulse and sticky seq_err for one register. Inputs: wr_en, wdata, clr.
- Top level holds the FSM, wait counter and decode.

Test Plan:
- Reset, then write 32'h1 to 32'hABBA0000 with WAIT_CYCLES=1 -> pready_o high in 2nd access cycle, reg_a_o=1 next cycle, upd_o=3'b001 for one cycle, seq_err_o=0.
- Writes 5 then 3 to 32'hBAFF0000 -> reg_b_o=3, seq_err_o[1]=1 sticky. Then clr_err_i pulse -> seq_err_o=0. Then write 4 -> no error.
- Writes 32'hFFFFFFFF then 0 to 32'hCAFE0000 -> no seq_err (wrap). Then another 0 -> seq_err_o[2]=1.
- Write to 32'h12340000 -> pslverr_o=1 on the pready cycle, no upd_o, registers unchanged. Read 32'hABBA0000 -> prdata_o=reg_a_o, pslverr_o=0.
- WAIT_CYCLES=0 back-to-back writes A=7, B=9, C=11 -> pready_o in first access cycle of each, upd_o 001, 010, 100 in successive transfers.
- Deassert psel mid-access with WAIT_CYCLES=3 -> proto_err_o=1, no update. Also assert reset mid-access -> outputs 0 immediately, next transfer completes normally.

Source files
------------

// File: rtl/apb_event_sink_pkg.sv
// Shared types and constants for the APB event sink: FSM states, register slot
// indices, default event addresses and the wait-counter width.
package apb_event_sink_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    typedef enum logic [1:0] {
        SLOT_A,
        SLOT_B,
        SLOT_C,
        SLOT_NONE
    } slot_e;

    localparam logic [31:0] DEF_ADDR_A = 32'hABBA0000;
    localparam logic [31:0] DEF_ADDR_B = 32'hBAFF0000;
    localparam logic [31:0] DEF_ADDR_C = 32'hCAFE0000;

    localparam int CNT_W = 4;

    // Full 32-bit compare; anything that misses all three slots is unmapped.
    function automatic slot_e decode_slot(input logic [31:0] addr,
                                          input logic [31:0] addr_a,
                                          input logic [31:0] addr_b,
                                          input logic [31:0] addr_c);
        slot_e s;
        if (addr == addr_a)      s = SLOT_A;
        else if (addr == addr_b) s = SLOT_B;
        else if (addr == addr_c) s = SLOT_C;
        else                     s = SLOT_NONE;
        return s;
    endfunction

endpackage

// File: rtl/apb_event_sink_if.sv
// APB bus bundle between the event write master and the event sink completer.
interface apb_event_sink_if;
    // Handshake: a transfer starts with a setup cycle (psel=1, penable=0), then
    // access cycles (psel=1, penable=1) until the completer raises pready; the
    // transfer completes in the cycle where psel, penable and pready are all 1.
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_event_sink_event_reg_slot.sv
// One shadow register: value, valid bit, update pulse and a sticky flag that
// catches counter snapshots that fail to move forward.
module event_reg_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    input  logic        clr,
    output logic [31:0] value_o,
    output logic        upd_o,
    output logic        seq_err_o
);

    logic [31:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        upd_q, upd_d;
    logic        seq_err_q, seq_err_d;
    logic        wrap_ok;
    logic        backward;

    // A counter rolling over from all-ones to zero is forward progress.
    assign wrap_ok  = (value_q == 32'hFFFFFFFF) && (wdata == 32'h0);
    assign backward = valid_q && !wrap_ok && (wdata <= value_q);

    always_comb begin
        value_d   = value_q;
        valid_d   = valid_q;
        upd_d     = 1'b0;
        seq_err_d = seq_err_q & ~clr;
        if (wr_en) begin
            value_d = wdata;
            valid_d = 1'b1;
            upd_d   = 1'b1;
            if (backward) seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q   <= '0;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign value_o   = value_q;
    assign upd_o     = upd_q;
    assign seq_err_o = seq_err_q;

endmodule

// File: rtl/apb_event_sink.sv
// APB completer that captures event counter snapshots into three shadow
// registers, with programmable wait states, unmapped-address errors and read-back.
module apb_event_sink
    import apb_event_sink_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_A      = DEF_ADDR_A,
    parameter logic [31:0] ADDR_B      = DEF_ADDR_B,
    parameter logic [31:0] ADDR_C      = DEF_ADDR_C
) (
    input  logic                clk,
    input  logic                reset,
    apb_event_sink_if.slave     apb,
    output logic [31:0]         reg_a_o,
    output logic [31:0]         reg_b_o,
    output logic [31:0]         reg_c_o,
    output logic [2:0]          upd_o,
    output logic [2:0]          seq_err_o,
    output logic                proto_err_o,
    input  logic                clr_err_i,
    output state_e              dbg_state_o
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              proto_err_q, proto_err_d;

    logic              pready;
    slot_e             slot;
    logic [2:0]        wr_en;
    logic [31:0]       prdata;

    // Address, direction and data are captured at setup; the bus may wander
    // during the access phase without affecting the transfer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        proto_err_d = proto_err_q & ~clr_err_i;
        pready      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_INIT;
                    addr_d  = apb.paddr;
                    write_d = apb.pwrite;
                    wdata_d = apb.pwdata;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (apb.penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        pready  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign slot     = decode_slot(addr_q, ADDR_A, ADDR_B, ADDR_C);
    assign wr_en[0] = pready && write_q && (slot == SLOT_A);
    assign wr_en[1] = pready && write_q && (slot == SLOT_B);
    assign wr_en[2] = pready && write_q && (slot == SLOT_C);

    always_comb begin
        prdata = '0;
        if (pready && !write_q) begin
            unique case (slot)
                SLOT_A:  prdata = reg_a_o;
                SLOT_B:  prdata = reg_b_o;
                SLOT_C:  prdata = reg_c_o;
                default: prdata = '0;
            endcase
        end
    end

    event_reg_slot u_slot_a (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en[0]),
        .wdata     (wdata_q),
        .clr       (clr_err_i),
        .value_o   (reg_a_o),
        .upd_o     (upd_o[0]),
        .seq_err_o (seq_err_o[0])
    );

    event_reg_slot u_slot_b (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en[1]),
        .wdata     (wdata_q),
        .clr       (clr_err_i),
        .value_o   (reg_b_o),
        .upd_o     (upd_o[1]),
        .seq_err_o (seq_err_o[1])
    );

    event_reg_slot u_slot_c (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en[2]),
        .wdata     (wdata_q),
        .clr       (clr_err_i),
        .value_o   (reg_c_o),
        .upd_o     (upd_o[2]),
        .seq_err_o (seq_err_o[2])
    );

    assign apb.pready  = pready;
    assign apb.prdata  = prdata;
    assign apb.pslverr = pready && (slot == SLOT_NONE);

    assign proto_err_o = proto_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_event_sink.sv
// Bench for apb_event_sink: three instances (1, 0 and 3 wait states) share one
// driver; a per-instance register model predicts every observable value.
module tb_apb_event_sink;
    import apb_event_sink_pkg::*;

    localparam logic [31:0] A_ADDR = 32'hABBA0000;
    localparam logic [31:0] B_ADDR = 32'hBAFF0000;
    localparam logic [31:0] C_ADDR = 32'hCAFE0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clr_err = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared driver, gated per target ----------------
    int          tgt = 0;
    logic        d_psel = 1'b0;
    logic        d_penable = 1'b0;
    logic [31:0] d_paddr = '0;
    logic        d_pwrite = 1'b0;
    logic [31:0] d_pwdata = '0;

    apb_event_sink_if bus_w1();
    apb_event_sink_if bus_w0();
    apb_event_sink_if bus_w3();

    assign bus_w1.psel = d_psel && (tgt == 0);
    assign bus_w0.psel = d_psel && (tgt == 1);
    assign bus_w3.psel = d_psel && (tgt == 2);
    assign bus_w1.penable = d_penable && (tgt == 0);
    assign bus_w0.penable = d_penable && (tgt == 1);
    assign bus_w3.penable = d_penable && (tgt == 2);
    assign bus_w1.paddr = d_paddr;
    assign bus_w0.paddr = d_paddr;
    assign bus_w3.paddr = d_paddr;
    assign bus_w1.pwrite = d_pwrite;
    assign bus_w0.pwrite = d_pwrite;
    assign bus_w3.pwrite = d_pwrite;
    assign bus_w1.pwdata = d_pwdata;
    assign bus_w0.pwdata = d_pwdata;
    assign bus_w3.pwdata = d_pwdata;

    logic [31:0] reg_o [3][3];
    logic [2:0]  upd_v [3];
    logic [2:0]  seq_v [3];
    logic        proto_v [3];
    state_e      dbg_v [3];
    logic        pready_v [3];
    logic [31:0] prdata_v [3];
    logic        pslverr_v [3];

    assign pready_v[0] = bus_w1.pready;
    assign pready_v[1] = bus_w0.pready;
    assign pready_v[2] = bus_w3.pready;
    assign prdata_v[0] = bus_w1.prdata;
    assign prdata_v[1] = bus_w0.prdata;
    assign prdata_v[2] = bus_w3.prdata;
    assign pslverr_v[0] = bus_w1.pslverr;
    assign pslverr_v[1] = bus_w0.pslverr;
    assign pslverr_v[2] = bus_w3.pslverr;

    apb_event_sink #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .apb(bus_w1),
        .reg_a_o(reg_o[0][0]), .reg_b_o(reg_o[0][1]), .reg_c_o(reg_o[0][2]),
        .upd_o(upd_v[0]), .seq_err_o(seq_v[0]), .proto_err_o(proto_v[0]),
        .clr_err_i(clr_err), .dbg_state_o(dbg_v[0])
    );

    apb_event_sink #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .apb(bus_w0),
        .reg_a_o(reg_o[1][0]), .reg_b_o(reg_o[1][1]), .reg_c_o(reg_o[1][2]),
        .upd_o(upd_v[1]), .seq_err_o(seq_v[1]), .proto_err_o(proto_v[1]),
        .clr_err_i(clr_err), .dbg_state_o(dbg_v[1])
    );

    apb_event_sink #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .apb(bus_w3),
        .reg_a_o(reg_o[2][0]), .reg_b_o(reg_o[2][1]), .reg_c_o(reg_o[2][2]),
        .upd_o(upd_v[2]), .seq_err_o(seq_v[2]), .proto_err_o(proto_v[2]),
        .clr_err_i(clr_err), .dbg_state_o(dbg_v[2])
    );

    // ---------------- reference model ----------------
    int          wait_of [3] = '{1, 0, 3};
    logic [31:0] m_val [3][3];
    bit          m_valid [3][3];
    logic [2:0]  m_seq [3];
    bit          m_proto [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [31:0] addr);
        if (addr == A_ADDR) return 0;
        if (addr == B_ADDR) return 1;
        if (addr == C_ADDR) return 2;
        return 3;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_seq[d] = 3'b000;
            m_proto[d] = 1'b0;
            for (int s = 0; s < 3; s++) begin
                m_val[d][s] = '0;
                m_valid[d][s] = 1'b0;
            end
        end
    endfunction

    // Counter snapshots must move strictly forward, all-ones to zero being a rollover.
    function automatic void model_write(input int d, input int s, input logic [31:0] data);
        bit forward;
        forward = (longint'(data) > longint'(m_val[d][s])) ||
                  (m_val[d][s] == 32'hFFFFFFFF && data == 32'h0);
        if (m_valid[d][s] && !forward) m_seq[d][s] = 1'b1;
        m_val[d][s] = data;
        m_valid[d][s] = 1'b1;
    endfunction

    task automatic check_state(input int d, input string tag);
        chk({tag, "_reg_a"}, reg_o[d][0], m_val[d][0]);
        chk({tag, "_reg_b"}, reg_o[d][1], m_val[d][1]);
        chk({tag, "_reg_c"}, reg_o[d][2], m_val[d][2]);
        chk({tag, "_seq_err"}, 32'(seq_v[d]), 32'(m_seq[d]));
        chk({tag, "_proto_err"}, 32'(proto_v[d]), 32'(m_proto[d]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic xfer(input int d, input logic [31:0] addr, input bit wr, input logic [31:0] data);
        int cyc;
        int s;
        logic [2:0] exp_upd;
        s = slot_of(addr);
        tgt = d;
        @(negedge clk);
        d_psel = 1'b1; d_penable = 1'b0;
        d_paddr = addr; d_pwrite = wr; d_pwdata = data;
        @(negedge clk);
        d_penable = 1'b1;
        d_pwdata = ~data;
        #1;
        cyc = 1;
        while (!pready_v[d] && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("pready_latency", 32'(cyc), 32'(wait_of[d] + 1));
        chk("pslverr", 32'(pslverr_v[d]), 32'(s == 3));
        if (s == 3 || !wr) chk("prdata", prdata_v[d], (s == 3) ? 32'h0 : m_val[d][s]);
        @(negedge clk);
        d_psel = 1'b0; d_penable = 1'b0;
        #1;
        exp_upd = 3'b000;
        if (wr && s < 3) begin
            model_write(d, s, data);
            exp_upd[s] = 1'b1;
        end
        chk("upd_pulse", 32'(upd_v[d]), 32'(exp_upd));
        chk("idle_pslverr", 32'(pslverr_v[d]), 32'h0);
        chk("idle_prdata", prdata_v[d], 32'h0);
        check_state(d, "post");
        @(negedge clk);
        #1;
        chk("upd_drop", 32'(upd_v[d]), 32'h0);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            m_seq[d] = 3'b000;
            m_proto[d] = 1'b0;
            chk("clr_seq", 32'(seq_v[d]), 32'h0);
            chk("clr_proto", 32'(proto_v[d]), 32'h0);
        end
    endtask

    // Zero-wait writes to A, B, C with each setup in the cycle right after completion.
    task automatic b2b_w0(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] addr_tab [3];
        logic [31:0] dv [3];
        addr_tab = '{A_ADDR, B_ADDR, C_ADDR};
        dv = '{d0, d1, d2};
        tgt = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_psel = 1'b1; d_penable = 1'b0;
            d_paddr = addr_tab[i]; d_pwrite = 1'b1; d_pwdata = dv[i];
            #1;
            if (i > 0) chk("b2b_upd", 32'(upd_v[1]), 32'(3'b001 << (i - 1)));
            @(negedge clk);
            d_penable = 1'b1;
            #1;
            chk("b2b_pready", 32'(pready_v[1]), 32'h1);
            model_write(1, i, dv[i]);
        end
        @(negedge clk);
        d_psel = 1'b0; d_penable = 1'b0;
        #1;
        chk("b2b_upd_last", 32'(upd_v[1]), 32'h4);
        check_state(1, "b2b");
    endtask

    task automatic proto_drop_w3(input logic [31:0] data);
        tgt = 2;
        @(negedge clk);
        d_psel = 1'b1; d_penable = 1'b0;
        d_paddr = A_ADDR; d_pwrite = 1'b1; d_pwdata = data;
        @(negedge clk);
        d_penable = 1'b1;
        @(negedge clk);
        d_psel = 1'b0; d_penable = 1'b0;
        @(negedge clk);
        #1;
        m_proto[2] = 1'b1;
        chk("proto_upd", 32'(upd_v[2]), 32'h0);
        chk("proto_state", 32'(dbg_v[2]), 32'(IDLE));
        check_state(2, "proto");
    endtask

    task automatic reset_mid_access_w3();
        tgt = 2;
        @(negedge clk);
        d_psel = 1'b1; d_penable = 1'b0;
        d_paddr = B_ADDR; d_pwrite = 1'b1; d_pwdata = 32'h55;
        @(negedge clk);
        d_penable = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_pready", 32'(pready_v[2]), 32'h0);
        chk("rst_mid_upd", 32'(upd_v[2]), 32'h0);
        for (int d = 0; d < 3; d++) check_state(d, "rst_mid");
        @(negedge clk);
        d_psel = 1'b0; d_penable = 1'b0;
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_upd", 32'(upd_v[d]), 32'h0);
            chk("rst_pready", 32'(pready_v[d]), 32'h0);
            chk("rst_state", 32'(dbg_v[d]), 32'(IDLE));
            check_state(d, "rst");
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        xfer(0, A_ADDR, 1'b1, 32'h1);
        xfer(0, B_ADDR, 1'b1, 32'd5);
        xfer(0, B_ADDR, 1'b1, 32'd3);
        clr_pulse();
        xfer(0, B_ADDR, 1'b1, 32'd4);
        xfer(0, C_ADDR, 1'b1, 32'hFFFFFFFF);
        xfer(0, C_ADDR, 1'b1, 32'h0);
        xfer(0, C_ADDR, 1'b1, 32'h0);
        xfer(0, 32'h12340000, 1'b1, 32'd77);
        xfer(0, A_ADDR, 1'b0, 32'h0);
        b2b_w0(32'd7, 32'd9, 32'd11);
        proto_drop_w3(32'd8);
        reset_mid_access_w3();
        xfer(2, A_ADDR, 1'b1, 32'd8);
        xfer(2, A_ADDR, 1'b0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            int d;
            int s;
            logic [31:0] addr;
            logic [31:0] data;
            bit wr;
            d = $urandom_range(0, 2);
            s = $urandom_range(0, 3);
            case (s)
                0: addr = A_ADDR;
                1: addr = B_ADDR;
                2: addr = C_ADDR;
                default: addr = {16'h1234, 16'($urandom)};
            endcase
            wr = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: data = 32'hFFFFFFFF;
                1: data = 32'h0;
                2: data = $urandom;
                default: data = $urandom_range(0, 40);
            endcase
            xfer(d, addr, wr, data);
            if ($urandom_range(0, 9) == 0) clr_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
